// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data with data-first priority, starvation guard, fetch kill and response timeout.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifetch_req,
  input  logic [AW-1:0] ifetch_addr,
  input  logic          ifetch_kill,
  output logic [DW-1:0] ifetch_rdata,
  output logic          ifetch_ready,
  input  logic          dmem_req,
  input  logic          dmem_we,
  input  logic [AW-1:0] dmem_addr,
  input  logic [DW-1:0] dmem_wdata,
  output logic [DW-1:0] dmem_rdata,
  output logic          dmem_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  localparam logic [WW-1:0] TLAST = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, kill_q, kill_d, err_q, err_d, we_q, we_d, fe, gnt_i;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [DW-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
  logic [AW-1:0] addr_q, addr_d;
  always_comb begin
    fe = ifetch_req & ~ifetch_kill;
    gnt_i = fe & (~dmem_req | starve_q == SMAX);
    state_d = state_q;
    owner_d = owner_q;
    kill_d = kill_q;
    starve_d = starve_q;
    wait_d = wait_q;
    rdata_d = rdata_q;
    err_d = err_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        // an eligible fetch that loses can only lose to data below the limit, so +1 never overflows
        starve_d = (~fe | gnt_i) ? '0 : starve_q + 1'b1;
        if (gnt_i | dmem_req) begin
          state_d = ISSUE;
          owner_d = gnt_i;
          addr_d = gnt_i ? ifetch_addr : dmem_addr;
          we_d = ~gnt_i & dmem_we;
          wdata_d = gnt_i ? '0 : dmem_wdata;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        wait_d = '0;
        kill_d = kill_q | (owner_q & ifetch_kill);
      end
      WAIT: begin
        kill_d = kill_q | (owner_q & ifetch_kill);
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end else if (wait_q == TLAST) begin
          rdata_d = '0;
          err_d = 1'b1;
          state_d = RESP;
        end else wait_d = wait_q + 1'b1;
      end
      RESP: begin
        kill_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      kill_q <= 1'b0;
      starve_q <= '0;
      wait_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q <= kill_d;
      starve_q <= starve_d;
      wait_q <= wait_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
    end
  end
  assign mem_req = state_q == ISSUE;
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign ifetch_ready = state_q == RESP & owner_q & ~kill_q & ~ifetch_kill;
  assign dmem_ready = state_q == RESP & ~owner_q;
  assign ifetch_rdata = rdata_q;
  assign dmem_rdata = rdata_q;
  assign err = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic scored against a transaction-level model.
module tb_mem_port_arbiter;
  logic clk = 0, rst = 1;
  logic ifetch_req = 0, ifetch_kill = 0, dmem_req = 0, dmem_we = 0, mem_rvalid = 0;
  logic [31:0] ifetch_addr = 0, dmem_addr = 0, dmem_wdata = 0, mem_rdata = 0;
  logic [31:0] ifetch_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic ifetch_ready, dmem_ready, mem_req, mem_we, err;
  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] mem [logic [31:0]];
  int m_lat = 1, m_cnt = 0;
  bit m_mute = 0;
  logic [31:0] m_rd = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ifetch_req(ifetch_req), .ifetch_addr(ifetch_addr), .ifetch_kill(ifetch_kill),
    .ifetch_rdata(ifetch_rdata), .ifetch_ready(ifetch_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // memory macro: completes each issue m_lat cycles later unless muted
  always @(posedge clk) begin
    #1;
    mem_rvalid = 0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_mute) begin mem_rvalid = 1; mem_rdata = m_rd; end
    end
    if (mem_req) begin
      m_cnt = m_lat;
      if (mem_we) begin mem[mem_addr] = mem_wdata; m_rd = $urandom; end
      else m_rd = rd_mem(mem_addr);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic test_reset;
    rst = 1;
    tick(3);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, ifetch_ready, dmem_ready, err} !== '0) begin errors++; $display("FAIL reset_ctl got %b/%b/%h/%h/%b/%b/%b exp all 0", mem_req, mem_we, mem_addr, mem_wdata, ifetch_ready, dmem_ready, err); end
    checks++; if ({ifetch_rdata, dmem_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0", ifetch_rdata, dmem_rdata); end
    rst = 0;
    tick();
    checks++; if ({mem_req, ifetch_ready, dmem_ready, err} !== 4'b0) begin errors++; $display("FAIL reset_after got %b exp 0", {mem_req, ifetch_ready, dmem_ready, err}); end
  endtask

  task automatic test_load;
    mem[32'h100] = 32'hDEADBEEF; m_lat = 1;
    dmem_we = 0; dmem_addr = 32'h100; dmem_req = 1;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h100}) begin errors++; $display("FAIL load_issue got req %b we %b addr %h exp 1 0 100", mem_req, mem_we, mem_addr); end
    tick();
    checks++; if ({dmem_ready, ifetch_ready} !== 2'b00) begin errors++; $display("FAIL load_early got %b exp 00", {dmem_ready, ifetch_ready}); end
    tick();
    checks++; if ({dmem_ready, ifetch_ready} !== 2'b10) begin errors++; $display("FAIL load_ready got %b exp 10", {dmem_ready, ifetch_ready}); end
    checks++; if (dmem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h exp deadbeef", dmem_rdata); end
    dmem_req = 0;
    tick();
    checks++; if ({dmem_ready, ifetch_ready, mem_req} !== 3'b0) begin errors++; $display("FAIL load_idle got %b exp 000", {dmem_ready, ifetch_ready, mem_req}); end
  endtask

  task automatic test_store;
    m_lat = 3;
    dmem_we = 1; dmem_addr = 32'h40; dmem_wdata = 32'h12345678; dmem_req = 1;
    tick();
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h40, 32'h12345678}) begin errors++; $display("FAIL store_issue got %b %b %h %h exp 1 1 40 12345678", mem_req, mem_we, mem_addr, mem_wdata); end
    tick(3);
    checks++; if (dmem_ready !== 1'b0) begin errors++; $display("FAIL store_early got %b exp 0", dmem_ready); end
    tick();
    checks++; if (dmem_ready !== 1'b1) begin errors++; $display("FAIL store_ready got %b exp 1", dmem_ready); end
    dmem_req = 0; dmem_we = 0;
    tick();
  endtask

  task automatic test_starvation;
    logic [9:0] pat;
    int g = 0;
    pat = 10'b10_0001_0000;
    m_lat = 1;
    ifetch_addr = 32'h1000; dmem_addr = 32'h2000; dmem_we = 0;
    ifetch_req = 1; dmem_req = 1;
    for (int c = 0; c < 200 && g < 10; c++) begin
      tick();
      if (mem_req) begin
        checks++; if ((mem_addr == 32'h1000) !== pat[g]) begin errors++; $display("FAIL starve_grant%0d got fetch=%b exp fetch=%b", g, mem_addr == 32'h1000, pat[g]); end
        g++;
      end
    end
    checks++; if (g != 10) begin errors++; $display("FAIL starve_budget got %0d grants exp 10", g); end
    for (int c = 0; c < 20 && !ifetch_ready; c++) tick();
    ifetch_req = 0; dmem_req = 0;
    tick();
  endtask

  task automatic test_kill;
    mem[32'h80] = 32'hCAFE0080; mem[32'h84] = 32'hCAFE0084; m_lat = 2;
    ifetch_addr = 32'h0; ifetch_req = 1;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h0}) begin errors++; $display("FAIL kill_issue got %b %h exp 1 0", mem_req, mem_addr); end
    tick();
    ifetch_kill = 1; ifetch_req = 0;
    tick();
    ifetch_kill = 0;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({ifetch_ready, dmem_ready, mem_req} !== 3'b0) begin errors++; $display("FAIL kill_suppress%0d got %b exp 000", k, {ifetch_ready, dmem_ready, mem_req}); end
      tick();
    end
    m_lat = 1; ifetch_addr = 32'h80; ifetch_req = 1;
    tick();
    checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL refetch_issue got %b %h exp 1 80", mem_req, mem_addr); end
    tick(2);
    checks++; if ({ifetch_ready, ifetch_rdata} !== {1'b1, 32'hCAFE0080}) begin errors++; $display("FAIL refetch_ready got %b %h exp 1 cafe0080", ifetch_ready, ifetch_rdata); end
    ifetch_req = 0;
    tick();
    ifetch_addr = 32'h84; ifetch_req = 1;
    tick(3);
    checks++; if (ifetch_ready !== 1'b1) begin errors++; $display("FAIL resp_pre_kill got %b exp 1", ifetch_ready); end
    ifetch_kill = 1;
    #1;
    checks++; if (ifetch_ready !== 1'b0) begin errors++; $display("FAIL resp_kill got %b exp 0", ifetch_ready); end
    ifetch_req = 0; ifetch_kill = 0;
    tick();
    ifetch_req = 1; ifetch_kill = 1;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_kill got %b exp 0", mem_req); end
    ifetch_req = 0; dmem_addr = 32'h100; dmem_we = 0; dmem_req = 1;
    tick(3);
    checks++; if ({dmem_ready, dmem_rdata} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL data_under_kill got %b %h exp 1 deadbeef", dmem_ready, dmem_rdata); end
    dmem_req = 0; ifetch_kill = 0;
    tick();
  endtask

  task automatic test_timeout;
    m_mute = 1; m_lat = 1;
    dmem_addr = 32'h300; dmem_we = 0; dmem_req = 1;
    tick(2);
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++; if ({dmem_ready, err} !== 2'b00) begin errors++; $display("FAIL timeout_early%0d got %b exp 00", k, {dmem_ready, err}); end
    end
    tick();
    checks++; if ({dmem_ready, err, dmem_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL timeout_resp got %b %b %h exp 1 1 0", dmem_ready, err, dmem_rdata); end
    dmem_req = 0; m_mute = 0;
    tick();
    dmem_addr = 32'h100; dmem_req = 1;
    tick(3);
    checks++; if ({dmem_ready, dmem_rdata, err} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin errors++; $display("FAIL post_timeout got %b %h err %b exp 1 deadbeef 1", dmem_ready, dmem_rdata, err); end
    dmem_req = 0;
    tick();
  endtask

  task automatic test_reset_mid;
    m_lat = 4;
    dmem_addr = 32'h100; dmem_we = 0; dmem_req = 1;
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_issue got %b exp 1", mem_req); end
    tick();
    rst = 1; dmem_req = 0;
    tick();
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, ifetch_ready, dmem_ready, ifetch_rdata, dmem_rdata, err} !== '0) begin errors++; $display("FAIL rmid_zero%0d got %b %b %b %b %h exp all 0", k, mem_req, ifetch_ready, dmem_ready, err, dmem_rdata); end
      tick();
    end
    m_lat = 1; dmem_req = 1;
    tick(3);
    checks++; if ({dmem_ready, dmem_rdata, err} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL rmid_next got %b %h err %b exp 1 deadbeef 0", dmem_ready, dmem_rdata, err); end
    dmem_req = 0;
    tick();
  endtask

  task automatic test_random;
    bit fp = 0, dp = 0, dwe = 0, prev_f = 0, prev_d = 0, tx = 0, tx_i = 0, tx_we = 0, ei;
    logic [31:0] fa = 0, da = 0, dw = 0, tx_data = 0;
    int sc = 0, tx_cyc = 0, lat = 1;
    m_lat = 1;
    for (int c = 0; c < 1700; c++) begin
      tick();
      if (mem_req) begin
        ei = prev_f & (!prev_d | sc == 4);
        checks++; if (!(prev_f | prev_d) || tx) begin errors++; $display("FAIL rnd_spurious_issue at cycle %0d got req 1 exp 0", cyc); end
        checks++; if ({mem_addr, mem_we} !== (ei ? {fa, 1'b0} : {da, dwe})) begin errors++; $display("FAIL rnd_issue cycle %0d got %h %b exp %h %b", cyc, mem_addr, mem_we, ei ? fa : da, ei ? 1'b0 : dwe); end
        if (!ei && dwe) begin checks++; if (mem_wdata !== dw) begin errors++; $display("FAIL rnd_wdata got %h exp %h", mem_wdata, dw); end end
        tx = 1; tx_i = ei; tx_we = !ei && dwe;
        tx_data = rd_mem(ei ? fa : da);
        tx_cyc = cyc + lat + 1;
        sc = ei ? 0 : (prev_f ? sc + 1 : sc);
      end
      checks++; if ({ifetch_ready, dmem_ready} !== ((tx && cyc == tx_cyc) ? (tx_i ? 2'b10 : 2'b01) : 2'b00)) begin errors++; $display("FAIL rnd_ready cycle %0d got %b exp owner %s due %0d", cyc, {ifetch_ready, dmem_ready}, tx_i ? "I" : "D", tx_cyc); end
      if (tx && cyc == tx_cyc) begin
        if (!tx_we) begin checks++; if ((tx_i ? ifetch_rdata : dmem_rdata) !== tx_data) begin errors++; $display("FAIL rnd_rdata got %h exp %h", tx_i ? ifetch_rdata : dmem_rdata, tx_data); end end
        if (tx_i) fp = 0; else dp = 0;
        tx = 0;
      end
      if (c < 1500 && !fp && $urandom_range(0, 2) == 0) begin fp = 1; fa = 32'($urandom_range(0, 15)) << 2; sc = 0; end
      if (c < 1500 && !dp && $urandom_range(0, 2) == 0) begin dp = 1; da = 32'($urandom_range(0, 15)) << 2; dwe = 1'($urandom_range(0, 1)); dw = $urandom; end
      ifetch_req = fp; ifetch_addr = fa; dmem_req = dp; dmem_addr = da; dmem_we = dwe; dmem_wdata = dw;
      prev_f = fp; prev_d = dp;
      lat = $urandom_range(1, 4); m_lat = lat;
    end
    checks++; if (fp | dp | tx) begin errors++; $display("FAIL rnd_drain got pending %b%b%b exp 000", fp, dp, tx); end
    ifetch_req = 0; dmem_req = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_store();
    test_starvation();
    test_kill();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
